ext_bus_arbiter: RTL and testbench
==================================

// Module: ext_bus_arbiter
// PURPOSE
//  Shares the 21-bit external memory bus (adr, 8-bit data, n_read/n_write, four chip selects)
//  between two requesters: m0 (prog loader) and m1 (CPU/MBC path).
//  Arbitrates, then runs a timed SETUP/STROBE/HOLD cycle on the pins and returns read data.
//  Replaces the static n_reset pin mux in top; sits between those masters and the SB_IO pads.
// PARAMETERS
//  AW          21  address width
//  DW          8   data width
//  SETUP_CYC   1   cycles address/cs/data are valid before strobe (>=1)
//  STROBE_CYC  2   cycles n_read/n_write held low (>=1)
//  HOLD_CYC    1   cycles address/cs/data held after strobe (>=1)
//  PRIO        0   0 = round-robin, 1 = fixed priority m0 over m1
// PORTS
//  clk         in   1   bus clock
//  reset       in   1   async, active-high
//  mN_req      in   1   transaction request, N=0,1; hold fields stable until mN_ack
//  mN_we       in   1   1 = write, 0 = read
//  mN_adr      in   AW  byte address
//  mN_wdata    in   DW  write data
//  mN_cs       in   4   one-hot select {cram,crom,cart,ram} = bits {3,2,1,0}
//  mN_ack      out  1   one-cycle completion pulse
//  mN_rdata    out  DW  read data; valid in the ack cycle, held until the next mN read
//  bus_adr     out  AW  pin address
//  bus_dout    out  DW  pin write data
//  bus_doe     out  1   data pad output enable
//  bus_din     in   DW  pin read data
//  n_read      out  1   active-low read strobe
//  n_write     out  1   active-low write strobe
//  n_cs        out  4   active-low chip selects, same bit order as mN_cs
//  busy        out  1   FSM not IDLE
//  owner       out  1   port owning the current or last transaction
// BEHAVIOUR
//  Reset (async, takes effect immediately): state=IDLE, n_read=n_write=1, n_cs=4'hf, bus_doe=0,
//   bus_adr=0, bus_dout=0, mN_ack=0, mN_rdata=0, busy=0, owner=0, rr_last=1 (m0 wins first tie).
//  All pin outputs are registered; no combinational path from mN_* to pins.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE.
//   IDLE: if any req, grant and latch owner's we/adr/wdata/cs; go to SETUP. Else stay.
//    PRIO=1: m0 wins. PRIO=0: on a tie, grant the port != rr_last; a single requester always wins.
//    On grant, rr_last<=granted port.
//   SETUP (SETUP_CYC): bus_adr, n_cs=~cs asserted; on writes bus_dout valid and bus_doe=1.
//   STROBE (STROBE_CYC): n_read=0 on reads; n_write=0 on writes unless cs[2] (crom).
//    A ROM write is suppressed on the pins but otherwise completes normally and is acked.
//    Reads: bus_din is captured into owner's rdata at the edge that ends the last STROBE cycle.
//   HOLD (HOLD_CYC): strobes return to 1; adr/cs/dout/doe held.
//   DONE (1 cycle): n_cs=4'hf, bus_doe=0, owner's ack=1. The other port's ack stays 0.
//  Phase counter reloads on each phase entry. Its width is
//   $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1).
//  Latency: req seen in IDLE at cycle N -> ack in cycle N+SETUP_CYC+STROBE_CYC+HOLD_CYC+1.
//   Defaults give ack at N+5. Minimum spacing between transactions is one IDLE cycle.
//  Requester rule: in the cycle after ack, drop req or present a new transaction.
//   A still-high req in IDLE is a new request.
//  Requests arriving mid-transaction wait; nothing is queued beyond the req level.
//  Illegal cs (zero or multi-hot): passed through unchanged; no checking.
//  Reset mid-transaction: the transaction is aborted with no ack. A requester still holding
//   req after release is re-granted from SETUP.
// STRUCTURE
//  Package gb_bus_pkg: bus_state_t enum {IDLE,SETUP,STROBE,HOLD,DONE}; CS_RAM=0, CS_CART=1,
//   CS_CROM=2, CS_CRAM=3; default timing constants.
//  Sub-module ext_bus_timer: loadable down-counter for phase length, with a last-cycle flag.
//  Arbitration and capture registers stay in this module.
// TESTING
//  1 m1 read adr=0x1ABCD cs=0001, bus_din=0x5A while strobing -> n_cs[0] low 4 cycles, n_read low
//    2 cycles, m1_ack at N+5, m1_rdata=0x5A, n_write stays 1.
//  2 m0 write adr=0x0A000 cs=1000 wdata=0x3C -> bus_doe=1 and bus_dout=0x3C for 4 cycles,
//    n_write low 2 cycles mid-window, m0_ack at N+5.
//  3 m1 write cs=0100 (crom) -> n_write stays 1, n_cs[2] low 4 cycles, m1_ack still pulses.
//  4 both req held, 4 transactions: PRIO=0 -> grant order m0,m1,m0,m1.
//    PRIO=1 -> m0 only until m0 drops req.
//  5 reset raised mid-STROBE -> n_read/n_write/n_cs/bus_doe inactive before next edge, no ack;
//    after release, held req re-runs the full SETUP..DONE sequence.
//  6 SETUP=2 STROBE=3 HOLD=2, m1 back-to-back reads -> ack every 9 cycles (8 + 1 IDLE), rdata updates.

Source files
------------

// File: rtl/gb_bus_pkg.sv
// Shared types and constants for the external memory bus arbiter.
package gb_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } bus_state_t;

    // Chip-select bit positions in the one-hot cs field
    localparam int unsigned CS_RAM  = 0;
    localparam int unsigned CS_CART = 1;
    localparam int unsigned CS_CROM = 2;
    localparam int unsigned CS_CRAM = 3;

    localparam int unsigned DEF_AW         = 21;
    localparam int unsigned DEF_DW         = 8;
    localparam int unsigned DEF_SETUP_CYC  = 1;
    localparam int unsigned DEF_STROBE_CYC = 2;
    localparam int unsigned DEF_HOLD_CYC   = 1;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ext_bus_arbiter_if.sv
// Requester-side transaction port of the external bus arbiter.
interface ext_bus_arbiter_if #(
    parameter int unsigned AW = 21,
    parameter int unsigned DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    logic [3:0]    cs;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, adr, wdata, cs, input  ack, rdata);
    modport slave  (input  req, we, adr, wdata, cs, output ack, rdata);
endinterface

// File: rtl/ext_bus_timer.sv
// Loadable down-counter timing one bus phase; last_c flags the final cycle.
module ext_bus_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last_c
);
    logic [W-1:0] cnt_q, cnt_d;

    // Reload on phase entry, otherwise count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_c = (cnt_q == W'(1));
endmodule

// File: rtl/ext_bus_arbiter.sv
// Two-port arbiter running timed SETUP/STROBE/HOLD cycles on the external memory pins.
module ext_bus_arbiter
    import gb_bus_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned PRIO       = 0
) (
    input  logic           clk,
    input  logic           reset,
    ext_bus_arbiter_if.slave m0,
    ext_bus_arbiter_if.slave m1,
    output logic [AW-1:0]  bus_adr,
    output logic [DW-1:0]  bus_dout,
    output logic           bus_doe,
    input  logic [DW-1:0]  bus_din,
    output logic           n_read,
    output logic           n_write,
    output logic [3:0]     n_cs,
    output logic           busy,
    output logic           owner
);
    localparam int unsigned CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

    bus_state_t    state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_last_q, rr_last_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cs_q, cs_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          n_read_q, n_read_d, n_write_q, n_write_d;
    logic [3:0]    n_cs_q, n_cs_d;
    logic          bus_doe_q, bus_doe_d;
    logic          busy_q, busy_d;

    logic             grant_c;
    logic             last_c;
    logic             load_c;
    logic [CNT_W-1:0] load_val_c;
    logic             active_c;
    logic             strobe_c;

    ext_bus_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_c),
        .load_val (load_val_c),
        .last_c   (last_c)
    );

    // Arbitration, phase sequencing, read capture and next pin values
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        we_d       = we_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        cs_d       = cs_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        grant_c    = 1'b0;
        load_val_c = '0;

        case (state_q)
            IDLE: begin
                if (PRIO != 0) begin
                    grant_c = ~m0.req;
                end else if (m0.req && m1.req) begin
                    grant_c = ~rr_last_q;
                end else begin
                    grant_c = m1.req;
                end
                if (m0.req || m1.req) begin
                    state_d   = SETUP;
                    owner_d   = grant_c;
                    rr_last_d = grant_c;
                    we_d      = grant_c ? m1.we    : m0.we;
                    adr_d     = grant_c ? m1.adr   : m0.adr;
                    wdata_d   = grant_c ? m1.wdata : m0.wdata;
                    cs_d      = grant_c ? m1.cs    : m0.cs;
                end
            end
            SETUP: begin
                if (last_c) state_d = STROBE;
            end
            STROBE: begin
                if (last_c) begin
                    state_d = HOLD;
                    if (!we_q) begin
                        if (owner_q) rdata1_d = bus_din;
                        else         rdata0_d = bus_din;
                    end
                end
            end
            HOLD: begin
                if (last_c) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        load_c = (state_d != state_q);
        case (state_d)
            SETUP:   load_val_c = CNT_W'(SETUP_CYC);
            STROBE:  load_val_c = CNT_W'(STROBE_CYC);
            HOLD:    load_val_c = CNT_W'(HOLD_CYC);
            default: load_val_c = '0;
        endcase

        active_c  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        strobe_c  = (state_d == STROBE);
        n_cs_d    = active_c ? ~cs_d : 4'hf;
        bus_doe_d = active_c && we_d;
        n_read_d  = ~(strobe_c && !we_d);
        // ROM writes run the full cycle but never pulse n_write
        n_write_d = ~(strobe_c && we_d && !cs_d[CS_CROM]);
        ack0_d    = (state_d == DONE) && !owner_d;
        ack1_d    = (state_d == DONE) && owner_d;
        busy_d    = (state_d != IDLE);
    end

    // State, capture and pin registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdata_q   <= '0;
            cs_q      <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            n_read_q  <= 1'b1;
            n_write_q <= 1'b1;
            n_cs_q    <= 4'hf;
            bus_doe_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            cs_q      <= cs_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            n_read_q  <= n_read_d;
            n_write_q <= n_write_d;
            n_cs_q    <= n_cs_d;
            bus_doe_q <= bus_doe_d;
            busy_q    <= busy_d;
        end
    end

    assign bus_adr  = adr_q;
    assign bus_dout = wdata_q;
    assign bus_doe  = bus_doe_q;
    assign n_read   = n_read_q;
    assign n_write  = n_write_q;
    assign n_cs     = n_cs_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign m0.ack   = ack0_q;
    assign m0.rdata = rdata0_q;
    assign m1.ack   = ack1_q;
    assign m1.rdata = rdata1_q;
endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Bench for ext_bus_arbiter: default-timing round-robin instance and a slow fixed-priority instance.
`timescale 1ns/1ps
module tb_ext_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index [d][p]: d = 0 default instance, d = 1 (SETUP 2, STROBE 3, HOLD 2, PRIO 1)
    logic        req_r [2][2];
    logic        we_r  [2][2];
    logic [20:0] adr_r [2][2];
    logic [7:0]  wd_r  [2][2];
    logic [3:0]  cs_r  [2][2];
    logic        ack_w [2][2];
    logic [7:0]  rd_w  [2][2];
    logic [20:0] badr_w [2];
    logic [7:0]  bdout_w[2];
    logic        doe_w  [2];
    logic [7:0]  din_r  [2];
    logic        nrd_w  [2];
    logic        nwr_w  [2];
    logic [3:0]  ncs_w  [2];
    logic        busy_w [2];
    logic        own_w  [2];

    ext_bus_arbiter_if a_m0();
    ext_bus_arbiter_if a_m1();
    ext_bus_arbiter_if b_m0();
    ext_bus_arbiter_if b_m1();

    assign a_m0.req = req_r[0][0]; assign a_m0.we = we_r[0][0]; assign a_m0.adr = adr_r[0][0];
    assign a_m0.wdata = wd_r[0][0]; assign a_m0.cs = cs_r[0][0];
    assign ack_w[0][0] = a_m0.ack;  assign rd_w[0][0] = a_m0.rdata;
    assign a_m1.req = req_r[0][1]; assign a_m1.we = we_r[0][1]; assign a_m1.adr = adr_r[0][1];
    assign a_m1.wdata = wd_r[0][1]; assign a_m1.cs = cs_r[0][1];
    assign ack_w[0][1] = a_m1.ack;  assign rd_w[0][1] = a_m1.rdata;
    assign b_m0.req = req_r[1][0]; assign b_m0.we = we_r[1][0]; assign b_m0.adr = adr_r[1][0];
    assign b_m0.wdata = wd_r[1][0]; assign b_m0.cs = cs_r[1][0];
    assign ack_w[1][0] = b_m0.ack;  assign rd_w[1][0] = b_m0.rdata;
    assign b_m1.req = req_r[1][1]; assign b_m1.we = we_r[1][1]; assign b_m1.adr = adr_r[1][1];
    assign b_m1.wdata = wd_r[1][1]; assign b_m1.cs = cs_r[1][1];
    assign ack_w[1][1] = b_m1.ack;  assign rd_w[1][1] = b_m1.rdata;

    ext_bus_arbiter dut_a (
        .clk(clk), .reset(rst), .m0(a_m0), .m1(a_m1),
        .bus_adr(badr_w[0]), .bus_dout(bdout_w[0]), .bus_doe(doe_w[0]), .bus_din(din_r[0]),
        .n_read(nrd_w[0]), .n_write(nwr_w[0]), .n_cs(ncs_w[0]), .busy(busy_w[0]), .owner(own_w[0])
    );

    ext_bus_arbiter #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .PRIO(1)) dut_b (
        .clk(clk), .reset(rst), .m0(b_m0), .m1(b_m1),
        .bus_adr(badr_w[1]), .bus_dout(bdout_w[1]), .bus_doe(doe_w[1]), .bus_din(din_r[1]),
        .n_read(nrd_w[1]), .n_write(nwr_w[1]), .n_cs(ncs_w[1]), .busy(busy_w[1]), .owner(own_w[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: round-robin memory and per-port read data
    logic       rr_m [2];
    logic [7:0] rd_m [2][2];

    function automatic int s_of(input int d);    return (d == 0) ? 1 : 2; endfunction
    function automatic int t_of(input int d);    return (d == 0) ? 2 : 3; endfunction
    function automatic int h_of(input int d);    return (d == 0) ? 1 : 2; endfunction
    function automatic int prio_of(input int d); return (d == 0) ? 0 : 1; endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            rr_m[d] = 1'b1;
            for (int p = 0; p < 2; p++) rd_m[d][p] = 8'h00;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One transaction on port p of instance d; pre = IDLE cycles expected before SETUP
    task automatic run_txn(input int d, input int p, input logic we, input logic [20:0] adr,
                           input logic [7:0] wd, input logic [3:0] cs, input logic [7:0] dv,
                           input int pre, input bit keep);
        int s, t, h, ackk;
        logic inwin, instb, e_nrd, e_nwr, e_doe, e_busy;
        logic [3:0] e_ncs;
        s = s_of(d); t = t_of(d); h = h_of(d);
        ackk = pre + s + t + h + 1;
        we_r[d][p] = we; adr_r[d][p] = adr; wd_r[d][p] = wd; cs_r[d][p] = cs;
        req_r[d][p] = 1'b1;
        din_r[d] = ~dv;
        for (int k = 1; k <= ackk; k++) begin
            @(posedge clk);
            @(negedge clk);
            inwin  = (k > pre) && (k <= pre + s + t + h);
            instb  = (k > pre + s) && (k <= pre + s + t);
            e_ncs  = inwin ? ~cs : 4'hf;
            e_nrd  = !(instb && !we);
            e_nwr  = !(instb && we && !cs[2]);
            e_doe  = inwin && we;
            e_busy = (k > pre);
            n_vec++;
            if ({ncs_w[d], nrd_w[d], nwr_w[d], doe_w[d], busy_w[d]} !==
                {e_ncs, e_nrd, e_nwr, e_doe, e_busy}) begin
                n_err++;
                $display("FAIL pins d%0d p%0d k%0d: got ncs=%b rd=%b wr=%b doe=%b busy=%b want ncs=%b rd=%b wr=%b doe=%b busy=%b",
                         d, p, k, ncs_w[d], nrd_w[d], nwr_w[d], doe_w[d], busy_w[d],
                         e_ncs, e_nrd, e_nwr, e_doe, e_busy);
            end
            if (inwin) begin
                n_vec++;
                if (badr_w[d] !== adr || (we && bdout_w[d] !== wd)) begin
                    n_err++;
                    $display("FAIL addr/data d%0d k%0d: got adr=%h dout=%h want adr=%h dout=%h",
                             d, k, badr_w[d], bdout_w[d], adr, wd);
                end
            end
            n_vec++;
            if (ack_w[d][p] !== (k == ackk) || ack_w[d][1-p] !== 1'b0) begin
                n_err++;
                $display("FAIL ack d%0d p%0d k%0d: got ack=%b other=%b want ack=%b other=0",
                         d, p, k, ack_w[d][p], ack_w[d][1-p], (k == ackk));
            end
            din_r[d] = (k == pre + s + t) ? dv : ~dv;
        end
        if (!we) rd_m[d][p] = dv;
        n_vec++;
        if (own_w[d] !== 1'(p) || rd_w[d][p] !== rd_m[d][p] || rd_w[d][1-p] !== rd_m[d][1-p]) begin
            n_err++;
            $display("FAIL rdata/owner d%0d p%0d: got owner=%b rd=%h other=%h want owner=%0d rd=%h other=%h",
                     d, p, own_w[d], rd_w[d][p], rd_w[d][1-p], p, rd_m[d][p], rd_m[d][1-p]);
        end
        rr_m[d] = 1'(p);
        if (!keep) req_r[d][p] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req_r[d][p] = 1'b0; we_r[d][p] = 1'b0; adr_r[d][p] = '0;
                wd_r[d][p] = '0; cs_r[d][p] = '0;
            end
            din_r[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({nrd_w[d], nwr_w[d], ncs_w[d], doe_w[d], busy_w[d], own_w[d]} !== 9'b1_1_1111_0_0_0) begin
                n_err++;
                $display("FAIL reset ctrl d%0d: got rd=%b wr=%b ncs=%b doe=%b busy=%b owner=%b",
                         d, nrd_w[d], nwr_w[d], ncs_w[d], doe_w[d], busy_w[d], own_w[d]);
            end
            n_vec++;
            if (badr_w[d] !== 21'h0 || bdout_w[d] !== 8'h0) begin
                n_err++;
                $display("FAIL reset bus d%0d: got adr=%h dout=%h want 0", d, badr_w[d], bdout_w[d]);
            end
            for (int p = 0; p < 2; p++) begin
                n_vec++;
                if (ack_w[d][p] !== 1'b0 || rd_w[d][p] !== 8'h00) begin
                    n_err++;
                    $display("FAIL reset port d%0d p%0d: got ack=%b rdata=%h want 0",
                             d, p, ack_w[d][p], rd_w[d][p]);
                end
            end
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_read();
        idle(2);
        run_txn(0, 1, 1'b0, 21'h1ABCD, 8'h00, 4'b0001, 8'h5A, 0, 1'b0);
    endtask

    task automatic test_write();
        idle(2);
        run_txn(0, 0, 1'b1, 21'h0A000, 8'h3C, 4'b1000, 8'h00, 0, 1'b0);
    endtask

    task automatic test_rom_write();
        idle(2);
        run_txn(0, 1, 1'b1, 21'h04321, 8'hE1, 4'b0100, 8'h00, 0, 1'b0);
    endtask

    // Both requesters held; expected winner derived from priority mode and last grant
    task automatic test_arbitration(input int d, input int n, input int drop_after);
        int s, t, h, cnt, exp_p;
        bit got;
        s = s_of(d); t = t_of(d); h = h_of(d);
        idle(2);
        for (int p = 0; p < 2; p++) begin
            we_r[d][p] = 1'b1; adr_r[d][p] = 21'($urandom); wd_r[d][p] = 8'($urandom);
            cs_r[d][p] = 4'b0001; req_r[d][p] = 1'b1;
        end
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (prio_of(d) != 0)                   exp_p = req_r[d][0] ? 0 : 1;
            else if (req_r[d][0] && req_r[d][1])   exp_p = rr_m[d] ? 0 : 1;
            else                                   exp_p = req_r[d][1] ? 1 : 0;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(posedge clk);
                @(negedge clk);
                cnt++;
                got = (ack_w[d][0] === 1'b1) || (ack_w[d][1] === 1'b1);
            end
            n_vec++;
            if (!got || ack_w[d][exp_p] !== 1'b1 || ack_w[d][1-exp_p] !== 1'b0 ||
                own_w[d] !== 1'(exp_p) || cnt != ((i == 0) ? s + t + h + 1 : s + t + h + 2)) begin
                n_err++;
                $display("FAIL arb d%0d txn%0d: got ack0=%b ack1=%b owner=%b cycles=%0d want port %0d after %0d",
                         d, i, ack_w[d][0], ack_w[d][1], own_w[d], cnt, exp_p,
                         (i == 0) ? s + t + h + 1 : s + t + h + 2);
            end
            rr_m[d] = 1'(exp_p);
            cnt = 0;
            if (i == drop_after) req_r[d][0] = 1'b0;
        end
        req_r[d][0] = 1'b0;
        req_r[d][1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        idle(2);
        we_r[0][0] = 1'b0; adr_r[0][0] = 21'h00123; cs_r[0][0] = 4'b0010;
        req_r[0][0] = 1'b1;
        din_r[0] = 8'hA7;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            seen = (nrd_w[0] === 1'b0);
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL reset_mid: read strobe never seen, got n_read=%b want 0", nrd_w[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({nrd_w[0], nwr_w[0], ncs_w[0], doe_w[0], busy_w[0], ack_w[0][0], ack_w[0][1]} !== 10'b1_1_1111_0_0_0_0) begin
            n_err++;
            $display("FAIL reset_mid async: got rd=%b wr=%b ncs=%b doe=%b busy=%b ack=%b%b want inactive",
                     nrd_w[0], nwr_w[0], ncs_w[0], doe_w[0], busy_w[0], ack_w[0][0], ack_w[0][1]);
        end
        @(negedge clk);
        n_vec++;
        if ({ncs_w[0], ack_w[0][0], ack_w[0][1]} !== 6'b1111_0_0) begin
            n_err++;
            $display("FAIL reset_mid hold: got ncs=%b ack=%b%b want 1111 00", ncs_w[0], ack_w[0][0], ack_w[0][1]);
        end
        rst = 1'b0;
        model_reset();
        run_txn(0, 0, 1'b0, 21'h00123, 8'h00, 4'b0010, 8'hA7, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        idle(2);
        run_txn(1, 1, 1'b0, 21'h10001, 8'h00, 4'b0001, 8'h11, 0, 1'b1);
        run_txn(1, 1, 1'b0, 21'h10002, 8'h00, 4'b0010, 8'h92, 1, 1'b1);
        run_txn(1, 1, 1'b0, 21'h10003, 8'h00, 4'b1000, 8'h6D, 1, 1'b0);
    endtask

    task automatic test_random(input int n);
        int d, p, last_d;
        logic we;
        logic [3:0] cs;
        last_d = -1;
        for (int i = 0; i < n; i++) begin
            d  = int'($urandom_range(0, 1));
            p  = int'($urandom_range(0, 1));
            we = 1'($urandom);
            cs = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            if (d == last_d && $urandom_range(0, 1) == 1) begin
                run_txn(d, p, we, 21'($urandom), 8'($urandom), cs, 8'($urandom), 1, 1'b0);
            end else begin
                idle(int'($urandom_range(1, 3)));
                run_txn(d, p, we, 21'($urandom), 8'($urandom), cs, 8'($urandom), 0, 1'b0);
            end
            last_d = d;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_rom_write();
        pulse_reset();
        test_arbitration(0, 4, -1);
        test_arbitration(1, 4, 2);
        test_reset_mid();
        test_back_to_back();
        test_random(30);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
